// File: rtl/acc_sched_if.sv
// Requester, accumulator and result signals of acc_sched, bundled into one port.
// The master side belongs to the requesters, the accumulator and the result sink.
interface acc_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int LENW = 8
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ*DW-1:0]   op_data;
  logic [NREQ-1:0]      op_valid;
  logic [NREQ-1:0]      op_ready;
  logic [DW-1:0]        acc_in;
  logic                 acc_in_valid;
  logic                 acc_clear;
  logic                 acc_is_output;
  logic [DW-1:0]        acc_out;
  logic [DW-1:0]        res_data;
  logic [IDW-1:0]       res_id;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;

  modport master (
    output req, req_len, op_data, op_valid, acc_out, res_ready,
    input  op_ready, acc_in, acc_in_valid, acc_clear, acc_is_output,
           res_data, res_id, res_valid, busy
  );

  modport slave (
    input  req, req_len, op_data, op_valid, acc_out, res_ready,
    output op_ready, acc_in, acc_in_valid, acc_clear, acc_is_output,
           res_data, res_id, res_valid, busy
  );
endinterface

// File: rtl/acc_sched.sv
// Round-robin scheduler that time-shares one external accumulator between NREQ
// requesters: clear, accumulate len operands, capture the sum, hand it out.
module acc_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int LENW = 8
) (
  input logic        clk,
  input logic        rst_n,
  acc_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  // state    | meaning
  // S_IDLE   | waiting for any req; picks the next requester round-robin
  // S_CLEAR  | one-cycle accumulator clear
  // S_ACCUM  | forwarding operands of the granted requester
  // S_DRAIN  | accumulator drives its sum, captured into res_data
  // S_RESULT | result offered until res_ready
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_RESULT} state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr, r_g, r_res_id;
  logic [IDW-1:0]  w_gnt, w_g_inc;
  logic [IDW:0]    w_sum;
  logic            w_any, w_beat, w_last;
  logic [LENW-1:0] r_len, r_cnt;
  logic [DW-1:0]   r_res_data;

  // Scan from the highest offset down so the lowest offset at/after r_rr_ptr wins.
  always_comb begin
    w_gnt = '0;
    w_any = 1'b0;
    w_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
      if (w_sum >= (IDW + 1)'(NREQ)) w_sum = w_sum - (IDW + 1)'(NREQ);
      if (bus.req[w_sum[IDW-1:0]]) begin
        w_gnt = w_sum[IDW-1:0];
        w_any = 1'b1;
      end
    end
  end

  assign w_g_inc = (r_g == IDW'(NREQ - 1)) ? '0 : r_g + 1'b1;
  assign w_beat  = (r_state == S_ACCUM) && bus.op_valid[r_g];
  assign w_last  = (r_cnt == r_len - 1'b1);

  always_comb begin
    w_state_nxt       = r_state;
    bus.op_ready      = '0;
    bus.acc_in        = '0;
    bus.acc_in_valid  = 1'b0;
    bus.acc_clear     = 1'b0;
    bus.acc_is_output = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        bus.acc_clear = 1'b1;
        w_state_nxt   = (r_len != '0) ? S_ACCUM : S_DRAIN;
      end
      S_ACCUM: begin
        bus.op_ready[r_g] = 1'b1;
        bus.acc_in        = bus.op_data[r_g*DW +: DW];
        bus.acc_in_valid  = bus.op_valid[r_g];
        if (w_beat && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.acc_is_output = 1'b1;
        w_state_nxt       = S_RESULT;
      end
      S_RESULT: begin
        if (bus.res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_g        <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_res_data <= '0;
      r_res_id   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g   <= w_gnt;
            r_len <= bus.req_len[w_gnt*LENW +: LENW];
          end
        end
        S_CLEAR: r_cnt <= '0;
        S_ACCUM: begin
          if (w_beat) r_cnt <= r_cnt + 1'b1;
        end
        S_DRAIN: begin
          r_res_data <= bus.acc_out;
          r_res_id   <= r_g;
        end
        S_RESULT: begin
          if (bus.res_ready) r_rr_ptr <= w_g_inc;
        end
        default: ;
      endcase
    end
  end

  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_res_id;
  assign bus.res_valid = (r_state == S_RESULT);
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_acc_sched.sv
// Self-checking bench for acc_sched: behavioural accumulator, burst runner and
// scenario tasks compared against arithmetic expectations.
module tb_acc_sched;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int LENW = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   m_ptr;

  acc_sched_if #(.NREQ(NREQ), .DW(DW), .LENW(LENW)) bus ();

  acc_sched #(.NREQ(NREQ), .DW(DW), .LENW(LENW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared accumulator the scheduler drives; garbage when not in output phase.
  logic [31:0] m_acc = 32'd0;
  always @(posedge clk) begin
    if (bus.acc_clear) m_acc <= 32'd0;
    else if (bus.acc_in_valid) m_acc <= m_acc + bus.acc_in;
  end
  assign bus.acc_out = bus.acc_is_output ? m_acc : 32'hDEAD_BEEF;

  logic [31:0] ops[256];
  int          o_clear_q[$];
  int          o_valid_q[$];
  int          o_out_q[$];
  logic [31:0] o_in_q[$];
  int          o_resv_cyc, o_hs_cyc, o_ready_cnt;
  bit          o_bad_ready, o_unstable, o_timeout, o_busy_bad, o_idle_after;
  logic [31:0] o_res_data;
  logic [1:0]  o_res_id;

  // Cycle (relative to the request cycle 0) of the k-th accepted operand.
  function automatic int beat_cyc(input logic [63:0] vpat, input int k);
    int n;
    n = 0;
    for (int c = 2; c < 2000; c++) begin
      if ((c - 2 < 64) ? vpat[c-2] : 1'b1) begin
        n++;
        if (n == k) return c;
      end
    end
    return -1;
  endfunction

  function automatic int rr_pick(input logic [3:0] mask, input int p);
    for (int k = 0; k < NREQ; k++)
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Drives one burst from cycle 0 (caller is between edges, DUT idle) and records
  // what the DUT did each cycle until one cycle after the result handshake.
  task automatic run_burst(input int id, input int len, input logic [63:0] vpat,
                           input int rdy_dly, input int drop_cyc);
    int  beat, hold;
    bit  done;
    o_clear_q.delete(); o_valid_q.delete(); o_out_q.delete(); o_in_q.delete();
    o_resv_cyc = -1; o_hs_cyc = -1; o_ready_cnt = 0;
    o_bad_ready = 0; o_unstable = 0; o_timeout = 0; o_busy_bad = 0; o_idle_after = 0;
    beat = 0; hold = 0; done = 0;
    bus.req = '0;
    bus.req[id] = 1'b1;
    bus.req_len[id*8 +: 8] = 8'(len);
    bus.op_valid = '0;
    bus.op_data[id*32 +: 32] = ops[0];
    bus.res_ready = 1'b0;
    for (int c = 1; c <= 700 && !done; c++) begin
      @(negedge clk);
      if (c >= drop_cyc) begin
        bus.req = '0;
        bus.req_len = $urandom;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (i != id) begin
          bus.op_data[i*32 +: 32] = $urandom;
          bus.op_valid[i] = 1'($urandom_range(0, 1));
        end
      end
      bus.op_valid[id] = (c < 2) ? 1'b0 : ((c - 2 < 64) ? vpat[c-2] : 1'b1);
      bus.op_data[id*32 +: 32] = ops[(beat < 256) ? beat : 0];
      #1;
      if (bus.acc_clear) o_clear_q.push_back(c);
      if (bus.acc_is_output) o_out_q.push_back(c);
      if (bus.op_ready == (4'b0001 << id)) o_ready_cnt++;
      else if (bus.op_ready != 4'b0000) o_bad_ready = 1;
      if (bus.acc_in_valid) begin
        o_valid_q.push_back(c);
        o_in_q.push_back(bus.acc_in);
        if (!bus.op_ready[id]) o_bad_ready = 1;
        beat++;
      end
      if (o_hs_cyc >= 0) begin
        o_idle_after = !bus.busy && !bus.res_valid;
        bus.res_ready = 1'b0;
        done = 1;
      end else begin
        if (!bus.busy) o_busy_bad = 1;
        if (o_resv_cyc >= 0 && !bus.res_valid) o_unstable = 1;
        if (bus.res_valid) begin
          if (o_resv_cyc < 0) begin
            o_resv_cyc = c;
            o_res_data = bus.res_data;
            o_res_id   = bus.res_id;
          end else if (bus.res_data !== o_res_data || bus.res_id !== o_res_id) begin
            o_unstable = 1;
          end
          if (hold >= rdy_dly) begin
            bus.res_ready = 1'b1;
            o_hs_cyc = c;
          end
          hold++;
        end
      end
    end
    if (!done) o_timeout = 1;
    bus.req = '0;
    bus.op_valid = '0;
    bus.res_ready = 1'b0;
    if (o_hs_cyc >= 0) m_ptr = (id + 1) % NREQ;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.req_len = '0; bus.op_data = '0; bus.op_valid = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.op_ready, bus.acc_in_valid, bus.acc_clear, bus.acc_is_output, bus.res_valid, bus.busy} !== 9'd0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {bus.op_ready, bus.acc_in_valid, bus.acc_clear, bus.acc_is_output, bus.res_valid, bus.busy});
    end
    n_checks++;
    if (bus.acc_in !== 32'd0 || bus.res_data !== 32'd0 || bus.res_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_data got acc_in=%h res_data=%h res_id=%0d exp=0", bus.acc_in, bus.res_data, bus.res_id);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int got[$], clr[$], hs[$];
    logic [31:0] val[4];
    int p0;
    p0 = m_ptr;
    for (int i = 0; i < NREQ; i++) begin
      val[i] = $urandom;
      bus.op_data[i*32 +: 32] = val[i];
    end
    bus.req = 4'hF; bus.req_len = {4{8'd1}}; bus.op_valid = 4'hF; bus.res_ready = 1'b1;
    for (int c = 1; c <= 200 && got.size() < 5; c++) begin
      @(negedge clk); #1;
      if (bus.acc_clear) clr.push_back(c);
      if (bus.res_valid) begin
        got.push_back(int'(bus.res_id));
        hs.push_back(c);
        n_checks++;
        if (bus.res_data !== val[bus.res_id]) begin
          n_fail++; $display("FAIL rr_data got=%h exp=%h", bus.res_data, val[bus.res_id]);
        end
      end
    end
    bus.req = '0;
    n_checks++;
    if (got.size() !== 5) begin n_fail++; $display("FAIL rr_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got[i] !== (p0 + i) % NREQ) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, got[i], (p0 + i) % NREQ); end
    end
    n_checks++;
    if (clr.size() < 5 || clr[0] !== 1) begin n_fail++; $display("FAIL rr_first_clear got=%0d exp=1", (clr.size() > 0) ? clr[0] : -1); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (clr[i+1] - hs[i] !== 2) begin n_fail++; $display("FAIL b2b_clear_gap[%0d] got=%0d exp=2", i, clr[i+1] - hs[i]); end
    end
    m_ptr = (p0 + 5) % NREQ;
    @(negedge clk);
    bus.res_ready = 1'b0; bus.op_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    ops[0] = 32'd5; ops[1] = 32'd7; ops[2] = 32'd9; ops[3] = 32'd100;
    run_burst(1, 3, {64{1'b1}}, 0, 1);
    n_checks++;
    if (o_timeout || o_clear_q.size() != 1 || o_clear_q[0] !== 1) begin n_fail++; $display("FAIL single_clear got=%0d exp=1", (o_clear_q.size() > 0) ? o_clear_q[0] : -1); end
    n_checks++;
    if (o_valid_q.size() != 3 || o_valid_q[0] !== 2 || o_valid_q[2] !== 4) begin n_fail++; $display("FAIL single_in_valid got n=%0d exp 3 beats at 2..4", o_valid_q.size()); end
    n_checks++;
    if (o_out_q.size() != 1 || o_out_q[0] !== 5) begin n_fail++; $display("FAIL single_is_output got=%0d exp=5", (o_out_q.size() > 0) ? o_out_q[0] : -1); end
    n_checks++;
    if (o_resv_cyc !== 6) begin n_fail++; $display("FAIL single_res_valid_cycle got=%0d exp=6", o_resv_cyc); end
    n_checks++;
    if (o_res_data !== 32'd21 || o_res_id !== 2'd1) begin n_fail++; $display("FAIL single_result got data=%0d id=%0d exp data=21 id=1", o_res_data, o_res_id); end
    n_checks++;
    if (o_in_q.size() != 3 || o_in_q[1] !== 32'd7) begin n_fail++; $display("FAIL single_acc_in got=%0d exp=7", (o_in_q.size() > 1) ? o_in_q[1] : 0); end
  endtask

  task automatic test_zero_len();
    ops[0] = $urandom;
    run_burst(2, 0, {64{1'b1}}, 0, 1);
    n_checks++;
    if (o_ready_cnt !== 0 || o_bad_ready || o_valid_q.size() != 0) begin n_fail++; $display("FAIL zero_op_ready got ready=%0d beats=%0d exp=0", o_ready_cnt, o_valid_q.size()); end
    n_checks++;
    if (o_out_q.size() != 1 || o_out_q[0] !== 2) begin n_fail++; $display("FAIL zero_drain got=%0d exp=2", (o_out_q.size() > 0) ? o_out_q[0] : -1); end
    n_checks++;
    if (o_timeout || o_resv_cyc !== 3 || o_res_data !== 32'd0 || o_res_id !== 2'd2) begin
      n_fail++; $display("FAIL zero_result got cyc=%0d data=%h id=%0d exp cyc=3 data=0 id=2", o_resv_cyc, o_res_data, o_res_id);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] sum;
    int exp_c[4];
    exp_c = '{2, 5, 6, 8};
    sum = 0;
    for (int i = 0; i < 8; i++) ops[i] = $urandom;
    for (int i = 0; i < 4; i++) sum += ops[i];
    run_burst(3, 4, 64'b1011001, 5, 1);
    n_checks++;
    if (o_valid_q.size() !== 4) begin n_fail++; $display("FAIL bp_beats got=%0d exp=4", o_valid_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (o_valid_q[i] !== exp_c[i]) begin n_fail++; $display("FAIL bp_beat_cycle[%0d] got=%0d exp=%0d", i, o_valid_q[i], exp_c[i]); end
    end
    n_checks++;
    if (o_resv_cyc !== 10 || o_hs_cyc !== 15) begin n_fail++; $display("FAIL bp_timing got resv=%0d hs=%0d exp 10/15", o_resv_cyc, o_hs_cyc); end
    n_checks++;
    if (o_unstable) begin n_fail++; $display("FAIL bp_stable got unstable=1 exp=0"); end
    n_checks++;
    if (o_res_data !== sum || o_res_id !== 2'd3) begin n_fail++; $display("FAIL bp_result got %h/%0d exp %h/3", o_res_data, o_res_id, sum); end
    n_checks++;
    if (!o_idle_after) begin n_fail++; $display("FAIL bp_idle_after got=0 exp=1"); end
  endtask

  task automatic test_req_drop();
    logic [31:0] sum;
    sum = 0;
    for (int i = 0; i < 8; i++) ops[i] = $urandom;
    for (int i = 0; i < 3; i++) sum += ops[i];
    run_burst(0, 3, {64{1'b1}}, 1, 3);
    n_checks++;
    if (o_valid_q.size() !== 3) begin n_fail++; $display("FAIL drop_beats got=%0d exp=3", o_valid_q.size()); end
    n_checks++;
    if (o_timeout || o_res_data !== sum || o_res_id !== 2'd0 || o_resv_cyc !== 6) begin
      n_fail++; $display("FAIL drop_result got %h/%0d cyc=%0d exp %h/0 cyc=6", o_res_data, o_res_id, o_resv_cyc, sum);
    end
  endtask

  task automatic test_random_bursts();
    for (int n = 0; n < 12; n++) begin
      int id, len, dly, last, mm;
      logic [63:0] vp;
      logic [31:0] sum;
      id  = $urandom_range(0, NREQ - 1);
      len = (n == 0) ? 1 : $urandom_range(0, 20);
      dly = $urandom_range(0, 3);
      vp  = {$urandom, $urandom};
      sum = 0;
      for (int i = 0; i <= len; i++) ops[i] = $urandom;
      for (int i = 0; i < len; i++) sum += ops[i];
      run_burst(id, len, vp, dly, 1);
      last = (len == 0) ? 1 : beat_cyc(vp, len);
      mm = 0;
      for (int i = 0; i < len; i++)
        if (o_valid_q[i] !== beat_cyc(vp, i + 1) || o_in_q[i] !== ops[i]) mm++;
      n_checks++;
      if (o_timeout || o_valid_q.size() != len || mm != 0) begin
        n_fail++; $display("FAIL rand_beats[%0d] got n=%0d bad=%0d exp n=%0d", n, o_valid_q.size(), mm, len);
      end
      n_checks++;
      if (o_clear_q.size() != 1 || o_clear_q[0] !== 1 || o_out_q.size() != 1 || o_out_q[0] !== last + 1) begin
        n_fail++; $display("FAIL rand_phases[%0d] got clr_n=%0d out=%0d exp out=%0d", n, o_clear_q.size(), (o_out_q.size() > 0) ? o_out_q[0] : -1, last + 1);
      end
      n_checks++;
      if (o_resv_cyc !== last + 2 || o_hs_cyc !== last + 2 + dly) begin
        n_fail++; $display("FAIL rand_res_timing[%0d] got %0d/%0d exp %0d/%0d", n, o_resv_cyc, o_hs_cyc, last + 2, last + 2 + dly);
      end
      n_checks++;
      if (o_ready_cnt !== last - 1 || o_bad_ready || o_busy_bad) begin
        n_fail++; $display("FAIL rand_op_ready[%0d] got cnt=%0d bad=%0d exp cnt=%0d", n, o_ready_cnt, o_bad_ready, last - 1);
      end
      n_checks++;
      if (o_res_data !== sum || o_res_id !== 2'(id) || o_unstable || !o_idle_after) begin
        n_fail++; $display("FAIL rand_result[%0d] got %h/%0d exp %h/%0d", n, o_res_data, o_res_id, sum, id);
      end
    end
  endtask

  task automatic test_rr_random();
    logic [31:0] val[4];
    int lens[4];
    logic [3:0] mask;
    logic [31:0] e;
    int exp_id, done_n, c;
    for (int i = 0; i < NREQ; i++) begin
      val[i]  = $urandom;
      lens[i] = $urandom_range(0, 2);
      bus.op_data[i*32 +: 32] = val[i];
      bus.req_len[i*8 +: 8]   = 8'(lens[i]);
    end
    bus.op_valid = 4'hF; bus.res_ready = 1'b1;
    mask = 4'($urandom_range(1, 15));
    bus.req = mask;
    exp_id = rr_pick(mask, m_ptr);
    done_n = 0; c = 0;
    while (done_n < 10 && c < 400) begin
      @(negedge clk); #1; c++;
      if (bus.res_valid) begin
        e = val[exp_id] * 32'(lens[exp_id]);
        n_checks++;
        if (bus.res_id !== 2'(exp_id) || bus.res_data !== e) begin
          n_fail++; $display("FAIL rr_rand[%0d] got id=%0d data=%h exp id=%0d data=%h", done_n, bus.res_id, bus.res_data, exp_id, e);
        end
        m_ptr = (exp_id + 1) % NREQ;
        done_n++;
        mask = 4'($urandom_range(1, 15));
        bus.req = (done_n < 10) ? mask : 4'h0;
        exp_id = rr_pick(mask, m_ptr);
      end
    end
    n_checks++;
    if (done_n !== 10) begin n_fail++; $display("FAIL rr_rand_timeout got=%0d exp=10", done_n); end
    bus.req = '0;
    @(negedge clk);
    bus.res_ready = 1'b0; bus.op_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_max_len();
    logic [31:0] sum;
    int id;
    id = $urandom_range(0, NREQ - 1);
    sum = 0;
    for (int i = 0; i < 256; i++) ops[i] = $urandom;
    for (int i = 0; i < 255; i++) sum += ops[i];
    run_burst(id, 255, {64{1'b1}}, 0, 1);
    n_checks++;
    if (o_valid_q.size() !== 255) begin n_fail++; $display("FAIL max_beats got=%0d exp=255", o_valid_q.size()); end
    n_checks++;
    if (o_timeout || o_resv_cyc !== 258 || o_res_data !== sum || o_res_id !== 2'(id)) begin
      n_fail++; $display("FAIL max_result got cyc=%0d %h/%0d exp cyc=258 %h/%0d", o_resv_cyc, o_res_data, o_res_id, sum, id);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] sum;
    bus.req = 4'b0100;
    bus.req_len[16 +: 8] = 8'd5;
    bus.op_valid = 4'b0100;
    bus.op_data[64 +: 32] = 32'h1234_5678;
    repeat (4) @(negedge clk);
    bus.req = '0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.acc_in_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got busy=%b in_valid=%b exp 1/1", bus.busy, bus.acc_in_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.op_ready, bus.acc_in_valid, bus.acc_clear, bus.acc_is_output, bus.res_valid, bus.busy} !== 9'd0) begin
      n_fail++; $display("FAIL arst_ctrl got=%b exp=0", {bus.op_ready, bus.acc_in_valid, bus.acc_clear, bus.acc_is_output, bus.res_valid, bus.busy});
    end
    n_checks++;
    if (bus.acc_in !== 32'd0 || bus.res_data !== 32'd0 || bus.res_id !== 2'd0) begin
      n_fail++; $display("FAIL arst_data got acc_in=%h res_data=%h res_id=%0d exp=0", bus.acc_in, bus.res_data, bus.res_id);
    end
    @(negedge clk);
    bus.op_valid = '0;
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_no_result got valid=%b busy=%b exp 0/0", bus.res_valid, bus.busy); end
    sum = 0;
    for (int i = 0; i < 8; i++) ops[i] = $urandom;
    for (int i = 0; i < 6; i++) sum += ops[i];
    run_burst(3, 6, {64{1'b1}}, 1, 1);
    n_checks++;
    if (o_timeout || o_res_data !== sum || o_res_id !== 2'd3 || o_resv_cyc !== 9) begin
      n_fail++; $display("FAIL arst_regrant got %h/%0d cyc=%0d exp %h/3 cyc=9", o_res_data, o_res_id, o_resv_cyc, sum);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_zero_len();
    test_backpressure();
    test_req_drop();
    test_random_bursts();
    test_rr_random();
    test_max_len();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
